adc_spi_emu: RTL and testbench
==============================

# adc_spi_emu

SPI responder that emulates eight parallel 16-bit serial ADCs sharing one chip-select and one SPI clock. Used in hardware-in-the-loop and loopback builds: it receives `cs_spi`/`clk_spi` from the ADC-reading SPI master and drives eight serial data lines with software-loaded sample words. All SPI inputs are asynchronous to `clk`; they are synchronised and edge-detected internally.

## Interface
- `DATA_W`, 16: bits per channel per frame.
- `SYNC_STAGES`, 2: flip-flop stages on `cs_spi` and `clk_spi`; minimum 2.
- `clk` input 1: system clock; all logic on its rising edge.
- `rstn` input 1: synchronous, active-low reset.
- `data` input 128: sample words; channel k (1..8) = `data[16k-1:16(k-1)]`.
- `load` input 1: one-cycle strobe; copies `data` into the holding register.
- `clk_spi` input 1: SPI clock from the master; idles high.
- `cs_spi` input 1: SPI chip-select from the master; active low.
- `sd_spi_1` .. `sd_spi_8` output 1 each: serial data, MSB first.
- `busy` output 1: frame in progress (synchronised CS low and frame accepted).
- `done` output 1: one-cycle pulse when a complete frame ends.
- `err_short` output 1: one-cycle pulse when CS rises before `DATA_W` rising SPI edges.
- `frame_count` output 32: completed frames; wraps from 0xFFFFFFFF to 0.

## Operation
- Holding register `hold[127:0]`: written on `load`, reset to 0.
- Shadow register `shift[127:0]`: eight 16-bit shift lanes. Loaded from `hold` on the CS falling edge. If `load` occurs in the same cycle as the CS fall, the shadow loads `data` directly (new value wins).
- `sd_spi_k` = MSB of lane k while `busy`; otherwise 0.
- On each synchronised `clk_spi` rising edge while `busy`, all lanes shift left by one and 0 enters the LSB. Bit counter `bit_cnt` (5 bits) increments and saturates at `DATA_W`.
- Rising edges beyond `DATA_W` are ignored: lanes stay at zero and no error is raised.
- `clk_spi` falling edges have no effect.
- States:
  - WAIT_IDLE: entered after reset. Leaves to IDLE only once synchronised CS is seen high, so a reset released mid-frame never starts a partial frame.
  - IDLE: on CS fall, load the shadow, clear `bit_cnt`, go to SHIFT.
  - SHIFT: on CS rise, if `bit_cnt` == `DATA_W`, pulse `done` and increment `frame_count`; otherwise pulse `err_short`. Then go to IDLE.
- CS rising and falling in consecutive synchronised samples are handled normally: a frame end followed by a new frame start.
- Reset (`rstn` = 0 for any cycle, including mid-frame) returns to WAIT_IDLE. It clears `hold`, `shift`, `bit_cnt` and `frame_count`, and forces all outputs to 0.

## Timing
- Reset values: `sd_spi_1..8` 0, `busy` 0, `done` 0, `err_short` 0, `frame_count` 0.
- Edge detection latency: `SYNC_STAGES`+1 `clk` cycles from pin transition to internal edge strobe.
- CS fall at the pin to `busy`=1 and MSB valid on `sd_spi_k`: `SYNC_STAGES`+2 cycles, registered outputs.
- `clk_spi` rise at the pin to the next bit on `sd_spi_k`: `SYNC_STAGES`+2 cycles.
- The master samples just before each rising edge. Each bit is therefore stable for one full SPI period minus the latency above. Supported: SPI half-period ≥ `SYNC_STAGES`+3 `clk` cycles, i.e. `clk_div` ≥ 5 at default settings.
- CS rise at the pin to `done`/`err_short` pulse: `SYNC_STAGES`+2 cycles. `busy` falls in the same cycle as the pulse. `frame_count` updates in the same cycle as `done`.
- `load` takes effect in `hold` on the next cycle. It may be asserted at any time; it never disturbs an active frame.

## Test plan
- Reset, then `load` with `data`=128'h8001_4002_2004_1008_0810_0420_0240_0180. Run the ADC SPI master with `clk_div`=5 -> master captures an identical 128-bit word; `done` pulses once; `frame_count`=1; `err_short` never asserts.
- Raise CS after 7 rising `clk_spi` edges -> `err_short` pulses once, `done` stays 0, `frame_count` unchanged, `sd_spi_k` return to 0.
- `load` 0xAAAA on all lanes during a frame whose shadow holds 0x5555 -> current frame delivers 0x5555; the next frame delivers 0xAAAA.
- Assert `load` with `data`=all 0x1234 in the exact cycle of the synchronised CS fall -> that frame delivers 0x1234 on every lane.
- Assert `rstn`=0 for 1 cycle at bit 8 of a frame and keep CS low -> outputs 0, no `done`/`err_short`. After CS rises and the next full frame completes -> `done` pulses and `frame_count`=1.
- Preload `frame_count` near the wrap point via 0xFFFFFFFF full frames (or force it) -> the next completed frame sets it to 0.

Source files
------------

// File: rtl/adc_spi_emu.sv
// Eight-channel serial ADC emulator: an SPI responder that shifts software-loaded
// DATA_W-bit samples out on eight data lines under an external CS / SPI clock.
module adc_spi_emu #(
    parameter int DATA_W      = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [8*DATA_W-1:0]   data,
    input  logic                  load,
    input  logic                  clk_spi,
    input  logic                  cs_spi,
    output logic                  sd_spi_1,
    output logic                  sd_spi_2,
    output logic                  sd_spi_3,
    output logic                  sd_spi_4,
    output logic                  sd_spi_5,
    output logic                  sd_spi_6,
    output logic                  sd_spi_7,
    output logic                  sd_spi_8,
    output logic                  busy,
    output logic                  done,
    output logic                  err_short,
    output logic [31:0]           frame_count
);

    localparam int NCH     = 8;
    localparam int LANES_W = NCH * DATA_W;
    localparam int CNT_W   = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        WAIT_IDLE,
        IDLE,
        SHIFT
    } state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
    logic                   cs_prev_q, cs_prev_d;
    logic                   sck_prev_q, sck_prev_d;
    logic                   cs_fall_q, cs_fall_d;
    logic                   cs_rise_q, cs_rise_d;
    logic                   sck_rise_q, sck_rise_d;

    logic [LANES_W-1:0]     hold_q, hold_d;
    logic [LANES_W-1:0]     shift_q, shift_d;
    logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [31:0]            frame_count_q, frame_count_d;
    logic [NCH-1:0]         sd_q, sd_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;

    // CS synchroniser resets low so WAIT_IDLE only leaves on a genuinely observed high CS.
    always_comb begin
        cs_sync_d  = {cs_sync_q[SYNC_STAGES-2:0], cs_spi};
        sck_sync_d = {sck_sync_q[SYNC_STAGES-2:0], clk_spi};
        cs_prev_d  = cs_sync_q[SYNC_STAGES-1];
        sck_prev_d = sck_sync_q[SYNC_STAGES-1];
        cs_fall_d  = cs_prev_q & ~cs_sync_q[SYNC_STAGES-1];
        cs_rise_d  = ~cs_prev_q & cs_sync_q[SYNC_STAGES-1];
        sck_rise_d = ~sck_prev_q & sck_sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cs_sync_q  <= '0;
            sck_sync_q <= '1;
            cs_prev_q  <= 1'b0;
            sck_prev_q <= 1'b1;
            cs_fall_q  <= 1'b0;
            cs_rise_q  <= 1'b0;
            sck_rise_q <= 1'b0;
        end else begin
            cs_sync_q  <= cs_sync_d;
            sck_sync_q <= sck_sync_d;
            cs_prev_q  <= cs_prev_d;
            sck_prev_q <= sck_prev_d;
            cs_fall_q  <= cs_fall_d;
            cs_rise_q  <= cs_rise_d;
            sck_rise_q <= sck_rise_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= WAIT_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            WAIT_IDLE: if (cs_prev_q) state_d = IDLE;
            IDLE:      if (cs_fall_q) state_d = SHIFT;
            SHIFT:     if (cs_rise_q) state_d = IDLE;
            default:   state_d = WAIT_IDLE;
        endcase
    end

    always_comb begin
        hold_d        = load ? data : hold_q;
        shift_d       = shift_q;
        bit_cnt_d     = bit_cnt_q;
        frame_count_d = frame_count_q;
        done_d        = 1'b0;
        err_d         = 1'b0;
        case (state_q)
            IDLE: begin
                if (cs_fall_q) begin
                    // a load coinciding with the frame start bypasses the holding register
                    shift_d   = load ? data : hold_q;
                    bit_cnt_d = '0;
                end
            end
            SHIFT: begin
                if (cs_rise_q) begin
                    shift_d = '0;
                    if (bit_cnt_q == CNT_FULL) begin
                        done_d        = 1'b1;
                        frame_count_d = frame_count_q + 32'd1;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (sck_rise_q && (bit_cnt_q != CNT_FULL)) begin
                    for (int unsigned k = 0; k < NCH; k++) begin
                        shift_d[k*DATA_W +: DATA_W] = {shift_q[k*DATA_W +: DATA_W-1], 1'b0};
                    end
                    bit_cnt_d = bit_cnt_q + CNT_ONE;
                end
            end
            default: ;
        endcase
        busy_d = (state_d == SHIFT);
        for (int unsigned k = 0; k < NCH; k++) begin
            sd_d[k] = busy_d & shift_d[k*DATA_W + DATA_W - 1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            hold_q        <= '0;
            shift_q       <= '0;
            bit_cnt_q     <= '0;
            frame_count_q <= '0;
            sd_q          <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            hold_q        <= hold_d;
            shift_q       <= shift_d;
            bit_cnt_q     <= bit_cnt_d;
            frame_count_q <= frame_count_d;
            sd_q          <= sd_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            err_q         <= err_d;
        end
    end

    assign sd_spi_1    = sd_q[0];
    assign sd_spi_2    = sd_q[1];
    assign sd_spi_3    = sd_q[2];
    assign sd_spi_4    = sd_q[3];
    assign sd_spi_5    = sd_q[4];
    assign sd_spi_6    = sd_q[5];
    assign sd_spi_7    = sd_q[6];
    assign sd_spi_8    = sd_q[7];
    assign busy        = busy_q;
    assign done        = done_q;
    assign err_short   = err_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_adc_spi_emu.sv
// Directed bench for adc_spi_emu: an SPI master model (clk_div = 5) captures the
// eight lanes and each scenario task checks data, pulses and frame counting.
module tb_adc_spi_emu;

    localparam int HALF = 5;
    localparam logic [127:0] D1 = 128'h8001_4002_2004_1008_0810_0420_0240_0180;
    localparam logic [127:0] D2 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic         load = 1'b0;
    logic         clk_spi = 1'b1;
    logic         cs_spi = 1'b1;
    logic [127:0] data = '0;
    logic [7:0]   sd;
    logic         busy;
    logic         done;
    logic         err_short;
    logic [31:0]  frame_count;

    int total = 0;
    int bad = 0;
    int done_seen = 0;
    int err_seen = 0;

    always #5 clk = ~clk;

    adc_spi_emu #(.DATA_W(16), .SYNC_STAGES(2)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .data        (data),
        .load        (load),
        .clk_spi     (clk_spi),
        .cs_spi      (cs_spi),
        .sd_spi_1    (sd[0]),
        .sd_spi_2    (sd[1]),
        .sd_spi_3    (sd[2]),
        .sd_spi_4    (sd[3]),
        .sd_spi_5    (sd[4]),
        .sd_spi_6    (sd[5]),
        .sd_spi_7    (sd[6]),
        .sd_spi_8    (sd[7]),
        .busy        (busy),
        .done        (done),
        .err_short   (err_short),
        .frame_count (frame_count)
    );

    always @(negedge clk) begin
        if (done) done_seen++;
        if (err_short) err_seen++;
    end

    task automatic load_word(input logic [127:0] w);
        data = w;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    // SPI master, mode 3: sample just before each rising edge, MSB first.
    task automatic spi_frame(input int nbits, input bit fall_load, input logic [127:0] fall_data,
                             input int mid_bit, input logic [127:0] mid_data,
                             input int rst_bit, input int gap,
                             output logic [127:0] cap, output int busy_lat);
        cap = '0;
        busy_lat = -1;
        cs_spi = 1'b0;
        for (int i = 1; i <= HALF; i++) begin
            @(negedge clk);
            if (busy && busy_lat < 0) busy_lat = i;
            if (fall_load && i == 3) begin
                data = fall_data;
                load = 1'b1;
            end else begin
                load = 1'b0;
            end
        end
        for (int b = 0; b < nbits; b++) begin
            if (b == rst_bit) begin
                rstn = 1'b0;
                @(negedge clk);
                rstn = 1'b1;
            end
            if (b == mid_bit) begin
                data = mid_data;
                load = 1'b1;
                @(negedge clk);
                load = 1'b0;
            end
            clk_spi = 1'b0;
            repeat (HALF) @(negedge clk);
            for (int k = 0; k < 8; k++) cap[k*16 + 15 - b] = sd[k];
            clk_spi = 1'b1;
            repeat (HALF) @(negedge clk);
        end
        cs_spi = 1'b1;
        repeat (gap) @(negedge clk);
    endtask

    task automatic test_reset;
        rstn = 1'b0;
        repeat (4) @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
        total++; if (err_short !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", err_short); end
        total++; if (sd !== 8'h00) begin bad++; $display("FAIL reset_sd got=%h exp=00", sd); end
        total++; if (frame_count !== 32'd0) begin bad++; $display("FAIL reset_fc got=%0d exp=0", frame_count); end
        rstn = 1'b1;
        repeat (8) @(negedge clk);
        total++; if (busy !== 1'b0 || sd !== 8'h00) begin bad++; $display("FAIL post_reset_idle got busy=%b sd=%h exp busy=0 sd=00", busy, sd); end
    endtask

    task automatic test_full_frame;
        logic [127:0] cap;
        int lat, d0, e0;
        load_word(D1);
        d0 = done_seen; e0 = err_seen;
        spi_frame(16, 1'b0, '0, -1, '0, -1, 10, cap, lat);
        total++; if (cap !== D1) begin bad++; $display("FAIL full_data got=%h exp=%h", cap, D1); end
        total++; if (done_seen - d0 !== 1) begin bad++; $display("FAIL full_done got=%0d exp=1", done_seen - d0); end
        total++; if (err_seen - e0 !== 0) begin bad++; $display("FAIL full_err got=%0d exp=0", err_seen - e0); end
        total++; if (frame_count !== 32'd1) begin bad++; $display("FAIL full_fc got=%0d exp=1", frame_count); end
        total++; if (lat !== 4) begin bad++; $display("FAIL busy_latency got=%0d exp=4", lat); end
        total++; if (busy !== 1'b0 || sd !== 8'h00) begin bad++; $display("FAIL full_idle got busy=%b sd=%h exp busy=0 sd=00", busy, sd); end
    endtask

    task automatic test_short_frame;
        logic [127:0] cap;
        int lat, d0, e0;
        d0 = done_seen; e0 = err_seen;
        spi_frame(7, 1'b0, '0, -1, '0, -1, 10, cap, lat);
        total++; if (cap !== 128'h8000_4000_2000_1000_0800_0400_0200_0000) begin bad++; $display("FAIL short_data got=%h exp=80004000200010000800040002000000", cap); end
        total++; if (err_seen - e0 !== 1) begin bad++; $display("FAIL short_err got=%0d exp=1", err_seen - e0); end
        total++; if (done_seen - d0 !== 0) begin bad++; $display("FAIL short_done got=%0d exp=0", done_seen - d0); end
        total++; if (frame_count !== 32'd1) begin bad++; $display("FAIL short_fc got=%0d exp=1", frame_count); end
        total++; if (sd !== 8'h00 || busy !== 1'b0) begin bad++; $display("FAIL short_idle got busy=%b sd=%h exp busy=0 sd=00", busy, sd); end
    endtask

    task automatic test_load_during_frame;
        logic [127:0] cap;
        int lat, d0;
        load_word({8{16'h5555}});
        d0 = done_seen;
        spi_frame(16, 1'b0, '0, 5, {8{16'hAAAA}}, -1, 10, cap, lat);
        total++; if (cap !== {8{16'h5555}}) begin bad++; $display("FAIL midload_cur got=%h exp=all 5555", cap); end
        spi_frame(16, 1'b0, '0, -1, '0, -1, 10, cap, lat);
        total++; if (cap !== {8{16'hAAAA}}) begin bad++; $display("FAIL midload_next got=%h exp=all AAAA", cap); end
        total++; if (done_seen - d0 !== 2) begin bad++; $display("FAIL midload_done got=%0d exp=2", done_seen - d0); end
        total++; if (frame_count !== 32'd3) begin bad++; $display("FAIL midload_fc got=%0d exp=3", frame_count); end
    endtask

    task automatic test_load_at_fall;
        logic [127:0] cap;
        int lat;
        spi_frame(16, 1'b1, {8{16'h1234}}, -1, '0, -1, 10, cap, lat);
        total++; if (cap !== {8{16'h1234}}) begin bad++; $display("FAIL fall_load_data got=%h exp=all 1234", cap); end
        total++; if (lat !== 4) begin bad++; $display("FAIL fall_load_latency got=%0d exp=4", lat); end
        spi_frame(16, 1'b0, '0, -1, '0, -1, 10, cap, lat);
        total++; if (cap !== {8{16'h1234}}) begin bad++; $display("FAIL fall_load_hold got=%h exp=all 1234", cap); end
        total++; if (frame_count !== 32'd5) begin bad++; $display("FAIL fall_load_fc got=%0d exp=5", frame_count); end
    endtask

    task automatic test_back_to_back;
        logic [127:0] cap1, cap2;
        int lat, d0, e0;
        load_word(D1);
        d0 = done_seen; e0 = err_seen;
        spi_frame(16, 1'b0, '0, 3, {8{16'h0F0F}}, -1, 1, cap1, lat);
        spi_frame(16, 1'b0, '0, -1, '0, -1, 10, cap2, lat);
        total++; if (cap1 !== D1) begin bad++; $display("FAIL b2b_first got=%h exp=%h", cap1, D1); end
        total++; if (cap2 !== {8{16'h0F0F}}) begin bad++; $display("FAIL b2b_second got=%h exp=all 0F0F", cap2); end
        total++; if (done_seen - d0 !== 2 || err_seen - e0 !== 0) begin bad++; $display("FAIL b2b_pulses got done=%0d err=%0d exp done=2 err=0", done_seen - d0, err_seen - e0); end
        total++; if (frame_count !== 32'd7) begin bad++; $display("FAIL b2b_fc got=%0d exp=7", frame_count); end
    endtask

    task automatic test_reset_mid_frame;
        logic [127:0] cap;
        int lat, d0, e0;
        load_word(D1);
        d0 = done_seen; e0 = err_seen;
        spi_frame(16, 1'b0, '0, -1, '0, 8, 10, cap, lat);
        total++; if (cap !== 128'h8000_4000_2000_1000_0800_0400_0200_0100) begin bad++; $display("FAIL rst_mid_data got=%h exp=80004000200010000800040002000100", cap); end
        total++; if (done_seen - d0 !== 0 || err_seen - e0 !== 0) begin bad++; $display("FAIL rst_mid_pulses got done=%0d err=%0d exp done=0 err=0", done_seen - d0, err_seen - e0); end
        total++; if (frame_count !== 32'd0) begin bad++; $display("FAIL rst_mid_fc got=%0d exp=0", frame_count); end
        load_word(D2);
        d0 = done_seen;
        spi_frame(16, 1'b0, '0, -1, '0, -1, 10, cap, lat);
        total++; if (cap !== D2) begin bad++; $display("FAIL rst_after_data got=%h exp=%h", cap, D2); end
        total++; if (done_seen - d0 !== 1) begin bad++; $display("FAIL rst_after_done got=%0d exp=1", done_seen - d0); end
        total++; if (frame_count !== 32'd1) begin bad++; $display("FAIL rst_after_fc got=%0d exp=1", frame_count); end
    endtask

    task automatic test_wrap;
        logic [127:0] cap;
        int lat, d0;
        force dut.frame_count_q = 32'hFFFF_FFFF;
        repeat (2) @(negedge clk);
        release dut.frame_count_q;
        @(negedge clk);
        total++; if (frame_count !== 32'hFFFF_FFFF) begin bad++; $display("FAIL wrap_preload got=%h exp=ffffffff", frame_count); end
        d0 = done_seen;
        spi_frame(16, 1'b0, '0, -1, '0, -1, 10, cap, lat);
        total++; if (frame_count !== 32'd0) begin bad++; $display("FAIL wrap_fc got=%h exp=00000000", frame_count); end
        total++; if (done_seen - d0 !== 1) begin bad++; $display("FAIL wrap_done got=%0d exp=1", done_seen - d0); end
    endtask

    initial begin
        @(negedge clk);
        test_reset;
        test_full_frame;
        test_short_frame;
        test_load_during_frame;
        test_load_at_fall;
        test_back_to_back;
        test_reset_mid_frame;
        test_wrap;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
